// File: rtl/apb_pkg.sv
// Shared constants and master FSM state type for the APB subsystem.
package apb_pkg;
    localparam int AW    = 9;
    localparam int DW    = 8;
    localparam int DEPTH = 2 ** (AW - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;
endpackage

// File: rtl/apb_slave.sv
// Zero-wait-state APB slave memory: writes commit on the ACCESS edge, reads are combinational.
module apb_slave
    import apb_pkg::*;
(
    input  logic          pclk,
    input  logic          presetn,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [AW-2:0] paddr,
    input  logic [DW-1:0] pwdata,
    output logic [DW-1:0] prdata,
    output logic          pready
);
    logic [DW-1:0] mem_reg [DEPTH];
    logic          access;

    assign access = psel && penable;
    assign pready = access;

    // Cleared on reset so a read of a never-written word returns zero rather than X.
    always_ff @(posedge pclk or posedge presetn) begin
        if (presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (access && pwrite) begin
            mem_reg[paddr] <= pwdata;
        end
    end

    assign prdata = (access && !pwrite) ? mem_reg[paddr] : '0;
endmodule

// File: rtl/apb_modport.sv
// APB master FSM driving two slave memories; address MSB picks the slave.
module apb_modport
    import apb_pkg::*;
(
    input  logic          pclk,
    input  logic          presetn,
    input  logic          transfer,
    input  logic          read_write,
    input  logic [AW-1:0] apb_write_paddr,
    input  logic [DW-1:0] apb_write_data,
    input  logic [AW-1:0] apb_read_paddr,
    output logic [DW-1:0] apb_read_data_out
);
    apb_state_t    state_reg, state_next;
    logic          capture;
    logic          rw_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg;
    logic [DW-1:0] rdata_reg;

    logic [1:0]    psel;
    logic [1:0]    pready_s;
    logic [DW-1:0] prdata_s [2];
    logic          penable;
    logic          pwrite;
    logic          pready;
    logic [DW-1:0] prdata;

    assign psel[0] = (state_reg != IDLE) && !addr_reg[AW-1];
    assign psel[1] = (state_reg != IDLE) &&  addr_reg[AW-1];
    assign penable = (state_reg == ACCESS);
    assign pwrite  = (state_reg != IDLE) && !rw_reg;
    assign pready  = |(psel & pready_s);
    assign prdata  = psel[1] ? prdata_s[1] : prdata_s[0];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slave
            apb_slave u_slave (
                .pclk    (pclk),
                .presetn (presetn),
                .psel    (psel[gi]),
                .penable (penable),
                .pwrite  (pwrite),
                .paddr   (addr_reg[AW-2:0]),
                .pwdata  (wdata_reg),
                .prdata  (prdata_s[gi]),
                .pready  (pready_s[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (transfer) begin
                    state_next = SETUP;
                    capture    = 1'b1;
                end
            end
            SETUP: state_next = ACCESS;
            ACCESS: begin
                if (pready) begin
                    // A pending request chains straight into SETUP without an IDLE gap.
                    if (transfer) begin
                        state_next = SETUP;
                        capture    = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge presetn) begin
        if (presetn) begin
            state_reg <= IDLE;
            rw_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                rw_reg    <= read_write;
                addr_reg  <= read_write ? apb_read_paddr : apb_write_paddr;
                wdata_reg <= apb_write_data;
            end
            if (penable && pready && rw_reg) begin
                rdata_reg <= prdata;
            end
        end
    end

    assign apb_read_data_out = rdata_reg;
endmodule

// File: tb/tb_apb_modport.sv
// Scoreboard bench for apb_modport: stimulus queues timed expectations, a negedge monitor checks them.
module tb_apb_modport;
    import apb_pkg::*;

    logic          pclk = 1'b0;
    logic          presetn;
    logic          transfer;
    logic          read_write;
    logic [AW-1:0] apb_write_paddr;
    logic [DW-1:0] apb_write_data;
    logic [AW-1:0] apb_read_paddr;
    logic [DW-1:0] apb_read_data_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int            due;
        logic [DW-1:0] exp;
        string         name;
    } sb_entry_t;

    sb_entry_t     sb[$];
    logic [DW-1:0] model_out;

    apb_modport dut (
        .pclk              (pclk),
        .presetn           (presetn),
        .transfer          (transfer),
        .read_write        (read_write),
        .apb_write_paddr   (apb_write_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_paddr    (apb_read_paddr),
        .apb_read_data_out (apb_read_data_out)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    always @(negedge pclk) begin : monitor
        sb_entry_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s: missed check slot got cycle %0d expected cycle %0d", e.name, cyc, e.due);
            end else begin
                chk(e.name, {24'd0, apb_read_data_out}, {24'd0, e.exp});
            end
        end
    end

    // Drives one request just after edge k; completion lands on edge k+3.
    task automatic do_op(input logic rd, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [DW-1:0] exp, input string name);
        int k;
        @(posedge pclk); #1;
        k               = cyc;
        transfer        = 1'b1;
        read_write      = rd;
        apb_write_paddr = rd ? '0 : addr;
        apb_read_paddr  = rd ? addr : '0;
        apb_write_data  = data;
        if (rd) begin
            sb.push_back('{k + 2, model_out, {name, "_early"}});
            sb.push_back('{k + 3, exp, name});
            model_out = exp;
        end else begin
            sb.push_back('{k + 3, model_out, {name, "_hold"}});
        end
        @(posedge pclk); #1;
        transfer        = 1'b0;
        apb_write_data  = 8'hEE;
        apb_write_paddr = 9'h1EE;
        apb_read_paddr  = 9'h1EE;
        @(posedge pclk);
        @(posedge pclk);
    endtask

    initial begin
        presetn         = 1'b1;
        transfer        = 1'b0;
        read_write      = 1'b0;
        apb_write_paddr = '0;
        apb_write_data  = '0;
        apb_read_paddr  = '0;
        model_out       = '0;

        repeat (3) @(posedge pclk);
        #1;
        chk("rst_out", {24'd0, apb_read_data_out}, 32'h0);
        chk("rst_state", {30'd0, dut.state_reg}, {30'd0, IDLE});
        chk("rst_psel", {30'd0, dut.psel}, 32'h0);
        chk("rst_penable", {31'd0, dut.penable}, 32'h0);
        presetn = 1'b0;

        do_op(1'b1, 9'h005, 8'h00, 8'h00, "rd_005");
        do_op(1'b0, 9'h010, 8'hA5, 8'h00, "wr_010");
        do_op(1'b1, 9'h010, 8'h00, 8'hA5, "rd_010");
        do_op(1'b0, 9'h040, 8'h99, 8'h00, "wr_040");

        do_op(1'b0, 9'h020, 8'h11, 8'h00, "wr_020");
        do_op(1'b0, 9'h120, 8'h22, 8'h00, "wr_120");
        do_op(1'b1, 9'h020, 8'h00, 8'h11, "rd_020");
        do_op(1'b1, 9'h120, 8'h00, 8'h22, "rd_120");
        do_op(1'b1, 9'h040, 8'h00, 8'h99, "rd_040");

        // Back-to-back writes: second request rides the first ACCESS edge.
        @(posedge pclk); #1;
        transfer        = 1'b1;
        read_write      = 1'b0;
        apb_write_paddr = 9'h0FF;
        apb_write_data  = 8'h5A;
        @(posedge pclk); #1;
        apb_write_paddr = 9'h1FF;
        apb_write_data  = 8'hC3;
        @(posedge pclk); #1;
        chk("b2b_access", {30'd0, dut.state_reg}, {30'd0, ACCESS});
        @(posedge pclk); #1;
        chk("b2b_no_idle", {30'd0, dut.state_reg}, {30'd0, SETUP});
        chk("b2b_psel2", {30'd0, dut.psel}, 32'h2);
        transfer = 1'b0;
        @(posedge pclk);
        @(posedge pclk);
        do_op(1'b1, 9'h0FF, 8'h00, 8'h5A, "rd_0ff");
        do_op(1'b1, 9'h1FF, 8'h00, 8'hC3, "rd_1ff");

        // Reset while the write sits in SETUP.
        @(posedge pclk); #1;
        transfer        = 1'b1;
        read_write      = 1'b0;
        apb_write_paddr = 9'h030;
        apb_write_data  = 8'h77;
        @(posedge pclk); #1;
        chk("mid_setup", {30'd0, dut.state_reg}, {30'd0, SETUP});
        presetn  = 1'b1;
        transfer = 1'b0;
        #1;
        chk("mid_rst_state", {30'd0, dut.state_reg}, {30'd0, IDLE});
        chk("mid_rst_out", {24'd0, apb_read_data_out}, 32'h0);
        model_out = '0;
        @(posedge pclk); #1;
        presetn = 1'b0;
        do_op(1'b1, 9'h030, 8'h00, 8'h00, "rd_030");

        repeat (3) @(posedge pclk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
